skew_feeder: RTL

SKEW_FEEDER -- requirements
Module: skew_feeder

---
 rtl/skew_feeder_if.sv | 25 ++
 rtl/skew_feeder.sv | 116 +++++++++++
 2 files changed

// File: rtl/skew_feeder_if.sv
// Handshake and row-FIFO strobe bundle between the upstream source, the skew feeder and its row FIFOs.
interface skew_feeder_if #(
    parameter int unsigned WORDLEN = 8,
    parameter int unsigned ROWS    = 4
);
    logic               start;
    logic               in_valid;
    logic [WORDLEN-1:0] in_data;
    logic               in_ready;
    logic [ROWS-1:0]    buf_write;
    logic [WORDLEN-1:0] buf_din;
    logic [ROWS-1:0]    buf_read;
    logic               busy;
    logic               done;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, buf_write, buf_din, buf_read, busy, done
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, buf_write, buf_din, buf_read, busy, done
    );
endinterface

// File: rtl/skew_feeder.sv
// Loads a ROWS x COLS tile row-major into per-row FIFOs, then issues diagonally skewed reads
// so row r starts draining r cycles after row 0.
module skew_feeder #(
    parameter int unsigned WORDLEN = 8,
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 4
) (
    input  logic         clk,
    input  logic         rstn,
    skew_feeder_if.slave bus
);
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DW = $clog2(ROWS + COLS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      col_cnt_q, col_cnt_d;
    logic [RW-1:0]      row_cnt_q, row_cnt_d;
    logic [DW-1:0]      drn_cnt_q, drn_cnt_d;
    logic [ROWS-1:0]    buf_write_q, buf_write_d;
    logic [WORDLEN-1:0] buf_din_q, buf_din_d;
    logic [ROWS-1:0]    buf_read_q, buf_read_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // drn_cnt 0 is the wait cycle; skew step t = drn_cnt-1, and the read register lags by one.
    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        buf_write_d = '0;
        buf_din_d   = buf_din_q;
        buf_read_d  = '0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    buf_write_d = ROWS'(1) << row_cnt_q;
                    buf_din_d   = bus.in_data;
                    if (col_cnt_q == CW'(COLS - 1)) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + RW'(1);
                        if (row_cnt_q == RW'(ROWS - 1)) begin
                            state_d   = S_DRAIN;
                            drn_cnt_d = '0;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                drn_cnt_d = drn_cnt_q + DW'(1);
                for (int unsigned r = 0; r < ROWS; r++) begin
                    buf_read_d[r] = (drn_cnt_q >= DW'(r + 1)) && (drn_cnt_q < DW'(r + 1 + COLS));
                end
                if (drn_cnt_q == DW'(ROWS + COLS)) begin
                    state_d   = S_DONE;
                    drn_cnt_d = '0;
                    done_d    = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            drn_cnt_q   <= '0;
            buf_write_q <= '0;
            buf_din_q   <= '0;
            buf_read_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            buf_write_q <= buf_write_d;
            buf_din_q   <= buf_din_d;
            buf_read_q  <= buf_read_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.buf_write = buf_write_q;
    assign bus.buf_din   = buf_din_q;
    assign bus.buf_read  = buf_read_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
